// File: rtl/sha3_pad_sequencer.sv
// SHA-3 block sequencer: cuts a 16-bit byte stream into rate-sized blocks, appends
// 0x06 .. 0x80 padding and holds each following block until the permutation is done.
module sha3_pad_sequencer #(
   parameter int WIDTH = 16,
   parameter int CNT_W = 7
) (
   input  logic             ACLK,
   input  logic             ARESET,
   input  logic [1:0]       mode,
   input  logic [WIDTH-1:0] s_tdata,
   input  logic [1:0]       s_tkeep,
   input  logic             s_tvalid,
   input  logic             s_tlast,
   output logic             s_tready,
   output logic [WIDTH-1:0] m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic             m_blk_end,
   output logic             m_msg_end,
   input  logic             core_done,
   output logic             busy
);

   typedef enum logic [1:0] {ST_IDLE, ST_ABSORB, ST_PAD, ST_WAIT_CORE} state_t;

   localparam logic [WIDTH-1:0] DOMAIN_PAD = 16'h0006;
   localparam logic [WIDTH-1:0] FINAL_BIT  = 16'h8000;

   state_t           state_reg, state_next;
   logic [CNT_W-1:0] wc_reg, wc_next;
   logic [CNT_W-1:0] rw_reg, rw_next, rw_cur;
   logic             pad_first_reg, pad_first_next;
   logic             final_pending_reg, final_pending_next;
   logic             msg_sent_reg, msg_sent_next;
   logic [WIDTH-1:0] data_reg, data_next;
   logic             valid_reg, valid_next;
   logic             blk_reg, blk_next;
   logic             msg_reg, msg_next;

   logic             at_last, out_free, blk_held, in_ready, load, load_msg;
   logic [WIDTH-1:0] load_data;

   function automatic logic [CNT_W-1:0] rate_words(input logic [1:0] m);
      case (m)
         2'd0:    rate_words = CNT_W'(72);
         2'd1:    rate_words = CNT_W'(68);
         2'd2:    rate_words = CNT_W'(52);
         default: rate_words = CNT_W'(36);
      endcase
   endfunction

   always_comb begin
      state_next         = state_reg;
      wc_next            = wc_reg;
      rw_next            = rw_reg;
      pad_first_next     = pad_first_reg;
      final_pending_next = final_pending_reg;
      msg_sent_next      = msg_sent_reg;
      data_next          = data_reg;
      valid_next         = valid_reg;
      blk_next           = blk_reg;
      msg_next           = msg_reg;
      load               = 1'b0;
      load_msg           = 1'b0;
      load_data          = '0;

      // The rate is taken straight from the mode pins for the first word of a message.
      rw_cur   = (state_reg == ST_IDLE) ? rate_words(mode) : rw_reg;
      at_last  = (wc_reg == rw_cur - CNT_W'(1));
      out_free = !valid_reg || m_ready;
      // Nothing more may enter the output register until a block-ending word has left.
      blk_held = valid_reg && blk_reg;
      in_ready = ((state_reg == ST_IDLE) || (state_reg == ST_ABSORB)) && out_free && !blk_held;

      if (valid_reg && m_ready) begin
         valid_next = 1'b0;
         blk_next   = 1'b0;
         msg_next   = 1'b0;
         if (blk_reg) begin
            state_next = ST_WAIT_CORE;
         end
      end

      case (state_reg)
         ST_IDLE, ST_ABSORB: begin
            if (in_ready && s_tvalid) begin
               load       = 1'b1;
               rw_next    = rw_cur;
               state_next = ST_ABSORB;
               if (!s_tlast) begin
                  load_data = s_tdata;
               end else if (s_tkeep == 2'b11) begin
                  load_data      = s_tdata;
                  pad_first_next = 1'b1;
                  if (at_last) begin
                     final_pending_next = 1'b1;
                  end else begin
                     state_next = ST_PAD;
                  end
               end else begin
                  load_data      = (s_tkeep == 2'b01) ? {8'h06, s_tdata[7:0]} : DOMAIN_PAD;
                  pad_first_next = 1'b0;
                  if (at_last) begin
                     load_data = load_data | FINAL_BIT;
                     load_msg  = 1'b1;
                  end else begin
                     state_next = ST_PAD;
                  end
               end
            end
         end
         ST_PAD: begin
            if (out_free && !blk_held) begin
               load           = 1'b1;
               load_data      = pad_first_reg ? DOMAIN_PAD : '0;
               pad_first_next = 1'b0;
               if (at_last) begin
                  load_data = load_data | FINAL_BIT;
                  load_msg  = 1'b1;
               end
            end
         end
         ST_WAIT_CORE: begin
            if (core_done) begin
               if (msg_sent_reg) begin
                  state_next    = ST_IDLE;
                  msg_sent_next = 1'b0;
               end else if (final_pending_reg) begin
                  state_next         = ST_PAD;
                  final_pending_next = 1'b0;
               end else begin
                  state_next = ST_ABSORB;
               end
            end
         end
         default: state_next = ST_IDLE;
      endcase

      if (load) begin
         data_next  = load_data;
         valid_next = 1'b1;
         blk_next   = at_last;
         msg_next   = load_msg;
         wc_next    = at_last ? '0 : wc_reg + CNT_W'(1);
         if (load_msg) begin
            msg_sent_next = 1'b1;
         end
      end
   end

   always_ff @(posedge ACLK or posedge ARESET) begin
      if (ARESET) begin
         state_reg         <= ST_IDLE;
         wc_reg            <= '0;
         rw_reg            <= '0;
         pad_first_reg     <= 1'b0;
         final_pending_reg <= 1'b0;
         msg_sent_reg      <= 1'b0;
         data_reg          <= '0;
         valid_reg         <= 1'b0;
         blk_reg           <= 1'b0;
         msg_reg           <= 1'b0;
      end else begin
         state_reg         <= state_next;
         wc_reg            <= wc_next;
         rw_reg            <= rw_next;
         pad_first_reg     <= pad_first_next;
         final_pending_reg <= final_pending_next;
         msg_sent_reg      <= msg_sent_next;
         data_reg          <= data_next;
         valid_reg         <= valid_next;
         blk_reg           <= blk_next;
         msg_reg           <= msg_next;
      end
   end

   assign s_tready  = in_ready;
   assign m_data    = data_reg;
   assign m_valid   = valid_reg;
   assign m_blk_end = blk_reg;
   assign m_msg_end = msg_reg;
   assign busy      = (state_reg != ST_IDLE);

endmodule

// File: doc/sha3_pad_sequencer.md
Name: sha3_pad_sequencer

Overview:
- Sits between the 16-bit AXI-Stream message input and the Keccak absorb datapath of the AXI SHA-3 core.
- Splits the incoming byte stream into rate-sized blocks for the selected SHA-3 variant, and appends SHA-3 padding (domain byte 0x06, final-bit 0x80).
- Emits each block as a word stream, then holds off the next block until the core reports that the permutation has completed.
- Replaces testbench-side block counting and last-block handling with RTL sequencing.

Parameters:
- WIDTH, 16, stream word width in bits; only 16 is supported.
- CNT_W, 7, width of the in-block word counter; must hold 0..71.

Ports:
- ACLK  in  1  clock.
- ARESET  in  1  asynchronous reset, active-high.
- mode  in  2  SHA-3 variant: 0=224, 1=256, 2=384, 3=512. Sampled on the first accepted word of a message.
- s_tdata  in  16  message word. Byte0 is in [7:0], byte1 is in [15:8].
- s_tkeep  in  2  valid bytes. Must be 11 except on the tlast word, where 11, 01 or 00 is allowed.
- s_tvalid  in  1  input word valid.
- s_tlast  in  1  last word of the message.
- s_tready  out  1  input accepted.
- m_data  out  16  word to the absorb datapath.
- m_valid  out  1  m_data valid.
- m_ready  in  1  absorb datapath accepts the word.
- m_blk_end  out  1  m_data is the last word of a rate block.
- m_msg_end  out  1  m_data is the last word of the final block.
- core_done  in  1  one-cycle pulse when the permutation of the current block has finished.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Rate words RW per mode: 72, 68, 52, 36 for modes 0..3.
- mode is latched on the first accepted word in IDLE. Changes to mode mid-message are ignored.
- Reset values: m_valid=0, m_data=0, m_blk_end=0, m_msg_end=0, busy=0, state=IDLE, word counter=0.
- Reset mid-operation abandons the message and any pending block. No flush words are emitted.
- Output stage is a single register; latency from input to output is 1 cycle.
- s_tready = (state in IDLE/ABSORB) && (!m_valid || m_ready).
- m_data, m_blk_end and m_msg_end hold stable while m_valid && !m_ready.
- A new output word loads only when !m_valid || m_ready.
- The word counter wc advances on each loaded word. A word loaded at wc==RW-1 sets m_blk_end, and wc wraps to 0.
- States:
  - IDLE: waits for s_tvalid. The first word is handled exactly as in ABSORB.
  - ABSORB: passes full words through. On the tlast word:
    - keep=11, wc<RW-1: load the data word; next state PAD with pad_first=1.
    - keep=11, wc==RW-1: load the data word with blk_end set; set final_pending=1 and pad_first=1; next state WAIT_CORE.
    - keep=01: load {8'h06, s_tdata[7:0]}. If wc==RW-1, OR in 0x8000 (giving 0x86 in the high byte) and set msg_end; otherwise go to PAD with pad_first=0.
    - keep=00: load 0x0006 (plus 0x8000 and msg_end if wc==RW-1); otherwise go to PAD with pad_first=0.
    - Any word with blk_end set moves the machine to WAIT_CORE.
  - PAD: the input is not ready. Each loaded word has base 0x0006 if pad_first, else 0x0000.
    - The word at wc==RW-1 additionally gets 0x8000 and msg_end.
    - pad_first clears after its word is loaded.
    - After the word with blk_end is accepted, go to WAIT_CORE.
  - WAIT_CORE: entered once the blk_end word has been accepted (m_valid && m_ready). Outputs idle; s_tready=0.
    - On core_done: if msg_end was sent, go to IDLE.
    - Else if final_pending, go to PAD (clearing final_pending).
    - Else go to ABSORB.
- A core_done pulse outside WAIT_CORE is ignored.
- m_msg_end is asserted only together with m_blk_end.
- A message that fills exactly k whole blocks produces k+1 blocks.

Test Plan:
- Empty message, mode=3: one input word with keep=00 and tlast -> 36 words: 0x0006, 34×0x0000, then 0x8000. Word 35 has blk_end=msg_end=1. Pulse core_done -> IDLE, busy=0.
- One byte 0xAB, mode=3, keep=01 -> word0=0x06AB, words 1-34 = 0x0000, word35=0x8000 with msg_end.
- Mode=3: 35 full words, then a tlast word with keep=01 and byte 0x5C -> word35=0x865C with blk_end=msg_end=1, and no extra block.
- Mode=0: exactly 72 full words -> block 1 passes through with blk_end on word 71 and msg_end=0, and s_tready stays low until core_done. Block 2 is then 0x0006, 70×0x0000, 0x8000 with msg_end.
- Backpressure: mode=1, hold m_ready low for 3 cycles at word 10 -> s_tready=0 and m_data stable for those cycles; the output sequence equals the input sequence with no loss or duplication.
- Assert ARESET during PAD at wc=20 -> m_valid=0 and busy=0 immediately. After release, s_tready=1 in IDLE and the next message starts at wc=0.
